// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int FETCH_WIDTH_DEFAULT = 32;
  localparam int PC_STEP_DEFAULT     = 4;
  localparam logic [FETCH_WIDTH_DEFAULT-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [FETCH_WIDTH_DEFAULT-1:0] pc;
    logic [FETCH_WIDTH_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_stage_sync_fifo.sv
// Small synchronous FIFO with flush; head is read combinationally from storage.
module sync_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [63:0]
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  T                         i_data,
  output T                         o_head,
  output logic [$clog2(DEPTH):0]   o_occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T                r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  // NOTE: storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head      = r_mem[r_rd_ptr];
  assign o_occupancy = r_count;

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage: PC register, imem address, {pc, instr} queue toward decode, redirect flush.
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = FETCH_WIDTH_DEFAULT,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
  parameter int               PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     redirect_valid,
  input  logic [WIDTH-1:0]         redirect_pc,
  output logic [WIDTH-1:0]         imem_addr,
  input  logic [WIDTH-1:0]         imem_rd,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [WIDTH-1:0]         dec_instr,
  output logic [WIDTH-1:0]         dec_pc,
  output logic [WIDTH-1:0]         dec_pc_plus4,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [WIDTH-1:0]         fetch_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]    FULL = CW'(DEPTH);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } entry_t;

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_fetch_cnt;
  logic [CW-1:0]    w_occ;
  logic             w_pop;
  logic             w_push;
  entry_t           w_wr_entry;
  entry_t           w_head;

  assign dec_valid = (w_occ != '0);
  assign w_pop     = dec_valid & dec_ready;
  // A full queue can still accept when decode frees the head this cycle.
  assign w_push    = en & ~redirect_valid & ((w_occ != FULL) | w_pop);

  assign w_wr_entry.pc    = r_pc;
  assign w_wr_entry.instr = imem_rd;

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .i_data      (w_wr_entry),
    .o_head      (w_head),
    .o_occupancy (w_occ)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc        <= RESET_PC;
      r_fetch_cnt <= '0;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (w_push) begin
      r_pc        <= r_pc + STEP;
      r_fetch_cnt <= r_fetch_cnt + WIDTH'(1);
    end
  end

  assign imem_addr    = r_pc;
  assign dec_instr    = w_head.instr;
  assign dec_pc       = w_head.pc;
  assign dec_pc_plus4 = w_head.pc + STEP;
  assign occupancy    = w_occ;
  assign fetch_cnt    = r_fetch_cnt;

endmodule
